// File: rtl/ascon_perm_ctrl_pkg.sv
// Shared types, Ascon round constants and the three combinational round layers
// used by the iterative permutation sequencer.
package ascon_perm_ctrl_pkg;

   typedef logic [4:0][63:0] type_state;

   localparam int unsigned ROUNDS_A = 12;
   localparam int unsigned ROUNDS_B = 6;
   localparam logic [3:0] LAST_IDX = 4'd11;
   // Both modes finish on the last constant, so p^b simply starts later in the table.
   localparam logic [3:0] START_IDX_A = 4'(LAST_IDX + 1 - ROUNDS_A);
   localparam logic [3:0] START_IDX_B = 4'(LAST_IDX + 1 - ROUNDS_B);

   localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

   function automatic logic [7:0] round_const(input logic [3:0] idx);
      return (idx > LAST_IDX) ? 8'h00 : RC[idx];
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic type_state pc(input type_state s, input logic [7:0] rc);
      type_state r;
      r = s;
      r[2][7:0] = s[2][7:0] ^ rc;
      return r;
   endfunction

   // Bitsliced 5-bit S-box: each bit lane of the five words is one S-box instance.
   function automatic type_state ps(input type_state s);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      type_state   r;
      x0 = s[0] ^ s[4];
      x1 = s[1];
      x2 = s[2] ^ s[1];
      x3 = s[3];
      x4 = s[4] ^ s[3];
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      r[0] = x0;
      r[1] = x1;
      r[2] = x2;
      r[3] = x3;
      r[4] = x4;
      return r;
   endfunction

   function automatic type_state pl(input type_state s);
      type_state r;
      r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
      r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
      r[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
      r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
      r[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
      return r;
   endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Request/status bundle between the AEAD controller (master) and the
// permutation sequencer (slave).
interface ascon_perm_ctrl_if;
   import ascon_perm_ctrl_pkg::*;

   logic       start_i;
   logic       mode_i;
   type_state  state_i;
   type_state  state_o;
   logic [3:0] round_o;
   logic       busy_o;
   logic       done_o;

   modport master (
      output start_i, mode_i, state_i,
      input  state_o, round_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i, state_i,
      output state_o, round_o, busy_o, done_o
   );
endinterface

// File: rtl/ascon_perm_ctrl_pround.sv
// One full Ascon round, purely combinational: constant addition, substitution
// layer, linear diffusion.
module ascon_perm_ctrl_pround
   import ascon_perm_ctrl_pkg::*;
(
   input  type_state  state,
   input  logic [7:0] rc,
   output type_state  result
);

   assign result = pl(ps(pc(state, rc)));

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation sequencer: loads a 320-bit state and applies one
// round per clock, running p^a (12 rounds) or p^b (6 rounds).
module ascon_perm_ctrl
   import ascon_perm_ctrl_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   ascon_perm_ctrl_if.slave  bus
);

   fsm_state_t state_q, state_d;
   type_state  perm_q;
   type_state  round_out;
   logic [3:0] idx_q;
   logic       load;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (idx_q == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            // A start here chains the next permutation with no idle bubble.
            state_d = bus.start_i ? RUN : IDLE;
            load    = bus.start_i;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset explicitly because state_o and
   // round_o are architecturally visible and must read zero after reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perm_q <= '0;
         idx_q  <= '0;
      end else if (load) begin
         perm_q <= bus.state_i;
         idx_q  <= bus.mode_i ? START_IDX_B : START_IDX_A;
      end else if (state_q == RUN) begin
         perm_q <= round_out;
         // Hold at the terminal index rather than stepping past the table.
         if (idx_q != LAST_IDX) idx_q <= idx_q + 4'd1;
      end
   end

   ascon_perm_ctrl_pround u_pround (
      .state  (perm_q),
      .rc     (round_const(idx_q)),
      .result (round_out)
   );

   always_comb begin
      bus.busy_o  = (state_q == RUN);
      bus.done_o  = (state_q == DONE);
      bus.round_o = (state_q == RUN) ? idx_q : 4'd0;
      bus.state_o = perm_q;
   end

endmodule
